rrf_free_list: RTL and testbench

//  Retirement register file (architectural arch->phys map) fused with the physical-register free list.

---
 rtl/rrf_free_list_pkg.sv | 19 +
 rtl/rrf_free_list_fifo.sv | 51 +++++
 rtl/rrf_free_list.sv | 70 +++++++
 tb/tb_rrf_free_list.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/rrf_free_list_pkg.sv
// Shared sizes and types for the retirement register file and its physical-register free list.
package rrf_free_list_pkg;
  localparam int NUM_ARCH_REG = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int ARCH_IDX_W   = $clog2(NUM_ARCH_REG);
  localparam int PHYS_IDX_W   = $clog2(NUM_PHYS_REG);
  localparam int FL_DEPTH     = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int FL_IDX_W     = $clog2(FL_DEPTH);
  localparam int FL_PTR_W     = FL_IDX_W + 1;

  typedef logic [ARCH_IDX_W-1:0] ARCH_REG_IDX;
  typedef logic [PHYS_IDX_W-1:0] PHYS_REG_IDX;

  typedef struct packed {
    logic        valid;
    ARCH_REG_IDX rd;
    PHYS_REG_IDX pd;
  } commit_entry_t;
endpackage

// File: rtl/rrf_free_list_fifo.sv
// Circular free list: one pop, up to two pushes per cycle, and a retire pointer that
// head can be restored to on a flush. Pointers carry an extra wrap bit.
module rrf_free_list_fifo
  import rrf_free_list_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pop_i,
  input  logic                  restore_i,
  input  logic [1:0]            push_vld_i,
  input  logic [PHYS_IDX_W-1:0] push_pd_i [2],
  output logic [PHYS_IDX_W-1:0] head_pd_o,
  output logic                  empty_o,
  output logic [FL_PTR_W-1:0]   count_o
);
  logic [PHYS_IDX_W-1:0] fl_q [FL_DEPTH];
  logic [FL_PTR_W-1:0]   head_q, head_d, retire_q, retire_d, tail_q, tail_d;
  logic [FL_IDX_W-1:0]   tail1_idx;
  logic [FL_PTR_W:0]     count_after0;
  logic                  push0_ok, push1_ok;

  assign count_o   = tail_q - head_q;
  assign empty_o   = (tail_q == head_q);
  assign head_pd_o = fl_q[head_q[FL_IDX_W-1:0]];

  // A push into a full list is dropped; register conservation means it never happens.
  always_comb begin
    push0_ok     = push_vld_i[0] && (count_o != FL_PTR_W'(FL_DEPTH));
    count_after0 = {1'b0, count_o} + (FL_PTR_W+1)'(push0_ok);
    push1_ok     = push_vld_i[1] && (count_after0 < (FL_PTR_W+1)'(FL_DEPTH));
    tail1_idx    = tail_q[FL_IDX_W-1:0] + FL_IDX_W'(push0_ok);
    tail_d       = tail_q + FL_PTR_W'(push0_ok) + FL_PTR_W'(push1_ok);
    retire_d     = retire_q + FL_PTR_W'(push0_ok) + FL_PTR_W'(push1_ok);
    head_d       = restore_i ? retire_d : head_q + FL_PTR_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      retire_q <= '0;
      tail_q   <= FL_PTR_W'(FL_DEPTH);
      for (int k = 0; k < FL_DEPTH; k++) fl_q[k] <= PHYS_IDX_W'(NUM_ARCH_REG + k);
    end else begin
      head_q   <= head_d;
      retire_q <= retire_d;
      tail_q   <= tail_d;
      if (push0_ok) fl_q[tail_q[FL_IDX_W-1:0]] <= push_pd_i[0];
      if (push1_ok) fl_q[tail1_idx] <= push_pd_i[1];
    end
  end
endmodule

// File: rtl/rrf_free_list.sv
// Retirement register file fused with the physical-register free list.
// Optional FREE_LIST_BYPASS_EN: an empty list may hand out lane0's freed register the same cycle.
module rrf_free_list
  import rrf_free_list_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_valid,
  output logic [PHYS_IDX_W-1:0] alloc_pd,
  input  logic [1:0]            commit_valid,
  input  logic [ARCH_IDX_W-1:0] commit_rd [2],
  input  logic [PHYS_IDX_W-1:0] commit_pd [2],
  input  logic                  branch_mispredict,
  output logic [PHYS_IDX_W-1:0] rrf_table [NUM_ARCH_REG],
  output logic [FL_PTR_W-1:0]   free_count
);
  logic [PHYS_IDX_W-1:0] rrf_q [NUM_ARCH_REG];
  commit_entry_t         lane [2];
  logic [PHYS_IDX_W-1:0] old_pd [2];
  logic [PHYS_IDX_W-1:0] fifo_pd;
  logic                  fifo_empty, pop;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      lane[l].valid = commit_valid[l] && (commit_rd[l] != '0);
      lane[l].rd    = commit_rd[l];
      lane[l].pd    = commit_pd[l];
    end
  end

  // Lane1 retiring the same rd as lane0 overwrites lane0's mapping, not the registered one.
  always_comb begin
    old_pd[0] = rrf_q[lane[0].rd];
    old_pd[1] = (lane[0].valid && (lane[0].rd == lane[1].rd)) ? lane[0].pd : rrf_q[lane[1].rd];
    rrf_table = rrf_q;
    for (int l = 0; l < 2; l++)
      if (lane[l].valid) rrf_table[lane[l].rd] = lane[l].pd;
  end

`ifdef FREE_LIST_BYPASS_EN
  assign alloc_valid = !fifo_empty || lane[0].valid;
  assign alloc_pd    = fifo_empty ? old_pd[0] : fifo_pd;
`else
  assign alloc_valid = !fifo_empty;
  assign alloc_pd    = fifo_pd;
`endif

  assign pop = alloc_req && alloc_valid && !branch_mispredict;

  rrf_free_list_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .pop_i     (pop),
    .restore_i (branch_mispredict),
    .push_vld_i({lane[1].valid, lane[0].valid}),
    .push_pd_i (old_pd),
    .head_pd_o (fifo_pd),
    .empty_o   (fifo_empty),
    .count_o   (free_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) rrf_q[i] <= PHYS_IDX_W'(i);
    end else begin
      rrf_q <= rrf_table;
    end
  end
endmodule

// File: tb/tb_rrf_free_list.sv
// Randomized bench for rrf_free_list against a queue-based model of free/in-flight registers.
module tb_rrf_free_list;
  import rrf_free_list_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst, alloc_req, alloc_valid, branch_mispredict;
  logic [PHYS_IDX_W-1:0] alloc_pd;
  logic [1:0]            commit_valid;
  logic [ARCH_IDX_W-1:0] commit_rd [2];
  logic [PHYS_IDX_W-1:0] commit_pd [2];
  logic [PHYS_IDX_W-1:0] rrf_table [NUM_ARCH_REG];
  logic [FL_PTR_W-1:0]   free_count;

  int total = 0;
  int bad   = 0;

  // Model: committed map, ordered free regs, and in-flight (allocated, not yet retired) regs.
  int amap [NUM_ARCH_REG];
  int flq [$];
  int spec_pd [$];
  int spec_rd [$];

  always #5 clk = ~clk;

  rrf_free_list dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (alloc_req),
    .alloc_valid      (alloc_valid),
    .alloc_pd         (alloc_pd),
    .commit_valid     (commit_valid),
    .commit_rd        (commit_rd),
    .commit_pd        (commit_pd),
    .branch_mispredict(branch_mispredict),
    .rrf_table        (rrf_table),
    .free_count       (free_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH_REG; i++) amap[i] = i;
    flq.delete();
    for (int k = 0; k < FL_DEPTH; k++) flq.push_back(NUM_ARCH_REG + k);
    spec_pd.delete();
    spec_rd.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; alloc_req = 1'b1; branch_mispredict = 1'b1; commit_valid = 2'b11;
    commit_rd[0] = 5'd3; commit_rd[1] = 5'd4; commit_pd[0] = 6'd60; commit_pd[1] = 6'd61;
    @(negedge clk);
    rst = 1'b0; alloc_req = 1'b0; branch_mispredict = 1'b0; commit_valid = 2'b00;
    model_reset();
    #1;
    chk("rst_alloc_valid", 32'(alloc_valid), 1);
    chk("rst_alloc_pd", 32'(alloc_pd), 32);
    chk("rst_free_count", 32'(free_count), 32);
    for (int i = 0; i < NUM_ARCH_REG; i++) chk($sformatf("rst_rrf[%0d]", i), 32'(rrf_table[i]), i);
  endtask

  // One cycle: optional alloc for arch reg ard, retire up to nc oldest in-flight regs, optional flush.
  task automatic step(input bit areq, input int ard, input int nc_req, input bit fl);
    int nc, old0, old1, ev, epd, popd;
    @(negedge clk);
    nc = (nc_req > spec_pd.size()) ? spec_pd.size() : nc_req;
    alloc_req = areq;
    branch_mispredict = fl;
    for (int l = 0; l < 2; l++) begin
      if (l < nc) begin
        commit_valid[l] = 1'b1;
        commit_rd[l] = ARCH_IDX_W'(spec_rd[l]);
        commit_pd[l] = PHYS_IDX_W'(spec_pd[l]);
      end else begin
        commit_valid[l] = ($urandom_range(0, 7) == 0);
        commit_rd[l] = '0;
        commit_pd[l] = PHYS_IDX_W'($urandom);
      end
    end
    old0 = 0; old1 = 0;
    if (nc > 0) begin old0 = amap[spec_rd[0]]; amap[spec_rd[0]] = spec_pd[0]; end
    if (nc > 1) begin old1 = amap[spec_rd[1]]; amap[spec_rd[1]] = spec_pd[1]; end
    ev = 0; epd = 0;
    if (flq.size() > 0) begin ev = 1; epd = flq[0]; end
`ifdef FREE_LIST_BYPASS_EN
    else if (nc > 0) begin ev = 1; epd = old0; end
`endif
    #1;
    chk("alloc_valid", 32'(alloc_valid), ev);
    if (ev != 0) chk("alloc_pd", 32'(alloc_pd), epd);
    chk("free_count", 32'(free_count), flq.size());
    for (int i = 0; i < NUM_ARCH_REG; i++) chk($sformatf("rrf_table[%0d]", i), 32'(rrf_table[i]), amap[i]);
    for (int l = 0; l < nc; l++) begin
      void'(spec_pd.pop_front());
      void'(spec_rd.pop_front());
    end
    if (nc > 0) flq.push_back(old0);
    if (nc > 1) flq.push_back(old1);
    if (areq && ev != 0 && !fl) begin
      popd = flq.pop_front();
      spec_pd.push_back(popd);
      spec_rd.push_back(ard);
    end
    if (fl) begin
      flq = {spec_pd, flq};
      spec_pd.delete();
      spec_rd.delete();
    end
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; branch_mispredict = 1'b0; commit_valid = 2'b00;
    commit_rd[0] = '0; commit_rd[1] = '0; commit_pd[0] = '0; commit_pd[1] = '0;
    do_reset();

    // Drain the list: pds 32..63 handed out, then one ignored request on empty.
    for (int i = 0; i < FL_DEPTH + 1; i++)
      step(1'b1, (i == 0) ? 5 : ((i < 3) ? 7 : $urandom_range(1, 31)), 0, 1'b0);
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    chk("empty_free_count", 32'(free_count), 0);
    chk("empty_alloc_valid", 32'(alloc_valid), 0);

    step(1'b1, 9, 1, 1'b0);  // rd5<-p32 while empty, with an alloc request
    step(1'b0, 1, 2, 1'b0);  // dual commit rd7: p33 then p34
    step(1'b1, 3, 0, 1'b0);
    step(1'b1, 4, 0, 1'b0);
    step(1'b1, 6, 1, 1'b1);  // commit and flush together, alloc ignored
    step(1'b1, 2, 0, 1'b0);

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 1) ? $urandom_range(1, 3) : $urandom_range(1, 31),
           $urandom_range(0, 2), $urandom_range(0, 49) == 0);

    do_reset();
    for (int n = 0; n < 200; n++)
      step($urandom_range(0, 9) < 8, $urandom_range(1, 31), $urandom_range(0, 2),
           $urandom_range(0, 29) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
